// File: rtl/dm_sba_mem_responder.sv
// SBA responder word memory: one transaction at a time, byte-enabled writes, configurable latencies.
// Optional error injection port enabled by defining DM_SBA_RESP_ERR_INJECT_EN.
module dm_sba_mem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned GNT_WAIT  = 0,
   parameter int unsigned RESP_LAT  = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        slave_req_i,
   input  logic [31:0] slave_add_i,
   input  logic        slave_we_i,
   input  logic [31:0] slave_wdata_i,
   input  logic [3:0]  slave_be_i,
`ifdef DM_SBA_RESP_ERR_INJECT_EN
   input  logic        err_inject_i,
`endif
   output logic        slave_gnt_o,
   output logic        slave_r_valid_o,
   output logic [31:0] slave_r_rdata_o,
   output logic        slave_r_err_o,
   output logic        slave_r_other_err_o
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  GntWait = 4'(GNT_WAIT);
   localparam logic [3:0]  LatInit = (RESP_LAT > 1) ? 4'(RESP_LAT - 2) : 4'd0;

   typedef enum logic [1:0] {StIdle, StLat, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic [3:0]    lat_cnt_q, lat_cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          other_err_q, other_err_d;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          inject;
   logic          gnt;
   logic          mem_we;
   logic          unused_offset;

   // BASE_ADDR is aligned to the window size, so range is a zero check on the upper offset bits.
   assign offset        = slave_add_i - BASE_ADDR;
   assign in_range      = (offset[31:AW+2] == '0);
   assign idx           = offset[AW+1:2];
   assign unused_offset = ^offset[1:0];

`ifdef DM_SBA_RESP_ERR_INJECT_EN
   assign inject = err_inject_i;
`else
   assign inject = 1'b0;
`endif

   assign gnt = (state_q == StIdle) && slave_req_i && (wait_cnt_q == GntWait);

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      other_err_d = other_err_q;
      mem_we      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!slave_req_i) begin
               wait_cnt_d = 4'd0;
            end else if (gnt) begin
               wait_cnt_d = 4'd0;
               rdata_d    = 32'h0;
               if (inject || (slave_be_i == 4'h0)) begin
                  err_d       = 1'b0;
                  other_err_d = 1'b1;
               end else if (!in_range) begin
                  err_d       = 1'b1;
                  other_err_d = 1'b0;
               end else begin
                  err_d       = 1'b0;
                  other_err_d = 1'b0;
                  mem_we      = slave_we_i;
                  if (!slave_we_i) rdata_d = mem[idx];
               end
               if (RESP_LAT == 1) begin
                  state_d = StResp;
               end else begin
                  state_d   = StLat;
                  lat_cnt_d = LatInit;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         StLat: begin
            if (lat_cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         StResp: begin
            state_d    = StIdle;
            wait_cnt_d = 4'd0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         wait_cnt_q  <= 4'd0;
         lat_cnt_q   <= 4'd0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         other_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         other_err_q <= other_err_d;
      end
   end

   // Contents survive reset; a grant coinciding with the reset edge must not write.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int k = 0; k < 4; k++) begin
            if (slave_be_i[k]) mem[idx][8*k +: 8] <= slave_wdata_i[8*k +: 8];
         end
      end
   end

   assign slave_r_valid_o     = (state_q == StResp);
   assign slave_r_rdata_o     = slave_r_valid_o ? rdata_q : 32'h0;
   assign slave_r_err_o       = slave_r_valid_o & err_q;
   assign slave_r_other_err_o = slave_r_valid_o & other_err_q;
   assign slave_gnt_o         = gnt;

endmodule

// File: tb/tb_dm_sba_mem_responder.sv
// Bench for dm_sba_mem_responder: two instances (fast and slow timing) checked against a word-array model.
module tb_dm_sba_mem_responder;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] add   [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic        gnt   [2];
   logic        rvalid[2];
   logic [31:0] rdata [2];
   logic        err   [2];
   logic        oerr  [2];

   logic [31:0] base [2] = '{32'h0000_1000, 32'h8000_0040};
   int          gw   [2] = '{0, 3};
   int          rl   [2] = '{1, 4};
   logic [31:0] mdl  [2][DEPTH];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   dm_sba_mem_responder #(
      .DEPTH(DEPTH), .BASE_ADDR(32'h0000_1000), .GNT_WAIT(0), .RESP_LAT(1)
   ) u_fast (
      .clk_i(clk), .rst_i(rst[0]), .slave_req_i(req[0]), .slave_add_i(add[0]),
      .slave_we_i(we[0]), .slave_wdata_i(wdata[0]), .slave_be_i(be[0]),
      .slave_gnt_o(gnt[0]), .slave_r_valid_o(rvalid[0]), .slave_r_rdata_o(rdata[0]),
      .slave_r_err_o(err[0]), .slave_r_other_err_o(oerr[0])
   );

   dm_sba_mem_responder #(
      .DEPTH(DEPTH), .BASE_ADDR(32'h8000_0040), .GNT_WAIT(3), .RESP_LAT(4)
   ) u_slow (
      .clk_i(clk), .rst_i(rst[1]), .slave_req_i(req[1]), .slave_add_i(add[1]),
      .slave_we_i(we[1]), .slave_wdata_i(wdata[1]), .slave_be_i(be[1]),
      .slave_gnt_o(gnt[1]), .slave_r_valid_o(rvalid[1]), .slave_r_rdata_o(rdata[1]),
      .slave_r_err_o(err[1]), .slave_r_other_err_o(oerr[1])
   );

   task automatic check(input string tag, input int i, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s (dut %0d): observed %h expected %h", tag, i, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input int i);
      check({tag, "_gnt"}, i, 32'(gnt[i]), 32'd0);
      check({tag, "_valid"}, i, 32'(rvalid[i]), 32'd0);
      check({tag, "_rdata"}, i, rdata[i], 32'd0);
      check({tag, "_errs"}, i, {30'd0, err[i], oerr[i]}, 32'd0);
   endtask

   // One full transaction; the model decides the expected response from address/be rules.
   task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
      logic [31:0] off, exp_rd;
      logic        exp_err, exp_oerr;
      int          c;
      bit          seen_valid, done;
      off      = a - base[i];
      exp_rd   = 32'h0;
      exp_err  = 1'b0;
      exp_oerr = 1'b0;
      if (b == 4'h0) begin
         exp_oerr = 1'b1;
      end else if (off >= 32'(4 * DEPTH)) begin
         exp_err = 1'b1;
      end else if (w) begin
         for (int k = 0; k < 4; k++)
            if (b[k]) mdl[i][int'(off >> 2)][8*k +: 8] = d[8*k +: 8];
      end else begin
         exp_rd = mdl[i][int'(off >> 2)];
      end
      req[i] = 1'b1; we[i] = w; add[i] = a; wdata[i] = d; be[i] = b;
      c = 0; seen_valid = 1'b0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (rvalid[i]) seen_valid = 1'b1;
         if (gnt[i] || c > 40) done = 1'b1;
         else c++;
      end
      check("gnt_latency", i, 32'(c), 32'(gw[i]));
      check("no_valid_before_gnt", i, 32'(seen_valid), 32'd0);
      @(posedge clk); #1;
      // Scramble inputs after grant: they must not be sampled again.
      req[i] = 1'b0; we[i] = 1'($urandom); add[i] = $urandom; wdata[i] = $urandom;
      be[i] = 4'($urandom);
      c = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         c++;
         if (rvalid[i] || c > 40) done = 1'b1;
      end
      check("resp_latency", i, 32'(c), 32'(rl[i]));
      check("r_err", i, 32'(err[i]), 32'(exp_err));
      check("r_other_err", i, 32'(oerr[i]), 32'(exp_oerr));
      if (!w || exp_err || exp_oerr) check("r_rdata", i, rdata[i], exp_rd);
      @(posedge clk); #1;
   endtask

   // Request held high continuously: grants and valids follow the back-to-back period.
   task automatic held(input int i);
      int q_g[$];
      int q_v[$];
      int per;
      per = gw[i] + rl[i] + 1;
      req[i] = 1'b1; we[i] = 1'b0; add[i] = base[i]; be[i] = 4'hF;
      for (int cyc = 0; cyc < 2 * per; cyc++) begin
         @(negedge clk);
         if (gnt[i]) q_g.push_back(cyc);
         if (rvalid[i]) q_v.push_back(cyc);
      end
      @(posedge clk); #1;
      req[i] = 1'b0;
      check("held_gnt_count", i, 32'(q_g.size()), 32'd2);
      check("held_valid_count", i, 32'(q_v.size()), 32'd2);
      if (q_g.size() == 2 && q_v.size() == 2) begin
         check("held_gnt0", i, 32'(q_g[0]), 32'(gw[i]));
         check("held_gnt1", i, 32'(q_g[1]), 32'(gw[i] + per));
         check("held_valid0", i, 32'(q_v[0]), 32'(gw[i] + rl[i]));
         check("held_valid1", i, 32'(q_v[1]), 32'(gw[i] + rl[i] + per));
      end
   endtask

   task automatic rand_txn(input int i);
      logic [31:0] a;
      logic [3:0]  b;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = base[i] + 32'(4 * DEPTH) + $urandom_range(0, 255);
      else if (r == 1) a = base[i] - 32'd1 - $urandom_range(0, 63);
      else             a = base[i] + $urandom_range(0, 4 * DEPTH - 1);
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(i, 1'($urandom), a, $urandom, b);
   endtask

   initial begin
      int vcount;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; add[i] = '0; wdata[i] = '0; be[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset", 0);
      check_idle_outputs("reset", 1);
      @(posedge clk); #1;

      for (int i = 0; i < 2; i++)
         for (int w = 0; w < int'(DEPTH); w++)
            txn(i, 1'b1, base[i] + 32'(4 * w), $urandom, 4'hF);

      // Directed cases on the fast instance.
      txn(0, 1'b1, base[0] + 32'h10, 32'hDEAD_BEEF, 4'hF);
      txn(0, 1'b0, base[0] + 32'h10, 32'h0, 4'hF);
      check("deadbeef_const", 0, mdl[0][4], 32'hDEAD_BEEF);
      txn(0, 1'b1, base[0] + 32'h14, 32'h1122_3344, 4'hF);
      txn(0, 1'b1, base[0] + 32'h14, 32'h0000_AB00, 4'b0010);
      txn(0, 1'b0, base[0] + 32'h16, 32'h0, 4'b0001);
      check("merge_const", 0, mdl[0][5], 32'h1122_AB44);
      txn(0, 1'b1, base[0] + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
      txn(0, 1'b0, base[0], 32'h0, 4'hF);
      txn(0, 1'b0, base[0] + 32'h8, 32'h0, 4'h0);
      txn(0, 1'b1, base[0] + 32'h8, 32'h5555_5555, 4'h0);
      txn(0, 1'b0, base[0] + 32'h8, 32'h0, 4'hF);

      held(0);
      held(1);

      // Withdrawn request on the slow instance clears the wait counter.
      req[1] = 1'b1; we[1] = 1'b1; add[1] = base[1] + 32'hC; wdata[1] = 32'hBAD0_BAD0; be[1] = 4'hF;
      repeat (2) begin
         @(negedge clk);
         check("withdrawn_no_gnt", 1, 32'(gnt[1]), 32'd0);
         @(posedge clk); #1;
      end
      req[1] = 1'b0;
      @(posedge clk); #1;
      txn(1, 1'b0, base[1] + 32'hC, 32'h0, 4'hF);

      // Reset during LAT on the slow instance: response dropped, write already done.
      req[1] = 1'b1; we[1] = 1'b1; add[1] = base[1] + 32'h8; wdata[1] = 32'hC0FF_EE11;
      be[1] = 4'hF;
      mdl[1][2] = 32'hC0FF_EE11;
      vcount = 0;
      while (!gnt[1] && vcount < 40) begin
         @(negedge clk);
         if (!gnt[1]) begin
            @(posedge clk); #1;
            vcount++;
         end
      end
      @(posedge clk); #1;
      req[1] = 1'b0;
      @(posedge clk); #1;
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_mid_reset", 1);
      vcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (rvalid[1]) vcount++;
      end
      check("dropped_response", 1, 32'(vcount), 32'd0);
      @(posedge clk); #1;
      txn(1, 1'b0, base[1] + 32'h8, 32'h0, 4'hF);

      // Grant coinciding with a reset edge on the fast instance must not write.
      rst[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b1; add[0] = base[0] + 32'h4;
      wdata[0] = ~mdl[0][1]; be[0] = 4'hF;
      @(posedge clk); #1;
      rst[0] = 1'b0; req[0] = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_gnt_reset", 0);
      @(posedge clk); #1;
      txn(0, 1'b0, base[0] + 32'h4, 32'h0, 4'hF);

      for (int n = 0; n < 60; n++) begin
         rand_txn(0);
         rand_txn(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
